// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 access modes,
// FSM state encoding, default wait-state count and request/response records.
package data_mem_responder_pkg;

  localparam int DEFAULT_WAIT_CYCLES = 2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  mode;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering for the data path: load extract/extend, store merge,
// and the misalign / illegal-mode flags for one access.
module dmem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  mode_i,
  input  logic        we_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wword_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{off_i, 3'b000} +: 8];
    half_v = word_i[{off_i[1], 4'b0000} +: 16];

    rdata_o = '0;
    case (mode_i)
      F3_LB:   rdata_o = {{24{byte_v[7]}}, byte_v};
      F3_LH:   rdata_o = {{16{half_v[15]}}, half_v};
      F3_LW:   rdata_o = word_i;
      F3_LBU:  rdata_o = {24'd0, byte_v};
      F3_LHU:  rdata_o = {16'd0, half_v};
      default: rdata_o = '0;
    endcase

    // Untouched lanes keep the old word so partial stores read-modify-write.
    wword_o = word_i;
    case (mode_i[1:0])
      2'b00:   wword_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      2'b01:   wword_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      2'b10:   wword_o = wdata_i;
      default: wword_o = word_i;
    endcase

    illegal_o  = (mode_i == 3'b011) | (mode_i[2:1] == 2'b11) | (we_i & mode_i[2]);
    misalign_o = ((mode_i[1:0] == 2'b01) & off_i[0]) |
                 ((mode_i[1:0] == 2'b10) & (off_i != 2'b00));
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with programmable wait states in
// front of a word-organised RAM; request and response on valid/ready.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [2:0]            req_mode_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o
);

  localparam int              IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]      WAIT_L = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_L = ADDR_WIDTH'(DEPTH_WORDS);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  req_t                  req_q;
  resp_t                 resp_q;
  logic [31:0]           mem_q [DEPTH_WORDS];

  logic                  accept, do_access;
  logic [ADDR_WIDTH-1:0] acc_addr;
  req_t                  acc_req;
  logic [31:0]           mem_word, ld_data, st_word;
  logic                  misalign, illegal, oor, acc_err;

  // With zero wait states the access happens in the accept cycle, so the
  // datapath looks at the live request instead of the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr = req_addr_i;
      acc_req  = '{we: req_we_i, mode: req_mode_i, wdata: req_wdata_i};
    end else begin
      acc_addr = addr_q;
      acc_req  = req_q;
    end
  end

  assign mem_word = mem_q[acc_addr[IDX_W+1:2]];
  assign oor      = (acc_addr >> 2) >= DEPTH_L;
  assign acc_err  = misalign | illegal | oor;

  dmem_lane_align u_align (
    .word_i     (mem_word),
    .wdata_i    (acc_req.wdata),
    .off_i      (acc_addr[1:0]),
    .mode_i     (acc_req.mode),
    .we_i       (acc_req.we),
    .rdata_o    (ld_data),
    .wword_o    (st_word),
    .misalign_o (misalign),
    .illegal_o  (illegal)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        cnt_d = WAIT_L;
        if (WAIT_L == 4'd0) begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: if (cnt_q == 4'd1) begin
        do_access = 1'b1;
        state_d   = ST_RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      ST_RESP: if (resp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == ST_IDLE) & ~rst_i;
    resp_valid_o = (state_q == ST_RESP);
    resp_rdata_o = resp_q.rdata;
    resp_err_o   = resp_q.err;
  end

  assign accept = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      addr_q <= '0;
      req_q  <= '0;
      resp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        addr_q <= req_addr_i;
        req_q  <= '{we: req_we_i, mode: req_mode_i, wdata: req_wdata_i};
      end
      if (do_access) begin
        resp_q.err   <= acc_err;
        resp_q.rdata <= (acc_err | acc_req.we) ? 32'd0 : ld_data;
      end else if (resp_valid_o & resp_ready_i) begin
        resp_q <= '0;
      end
    end
  end

  // RAM is never reset; reset on the commit edge still suppresses the write.
  always_ff @(posedge clk_i) begin
    if (do_access & acc_req.we & ~acc_err & ~rst_i)
      mem_q[acc_addr[IDX_W+1:2]] <= st_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses are queued as
// requests are issued and compared when the responder answers.
module tb_data_mem_responder;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [2:0]  req_mode_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_rdata_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_CYCLES(WAIT)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_we_i     (req_we_i),
    .req_mode_i   (req_mode_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  // Issue one request, optionally stall the response for 'hold' cycles.
  // Latency counts the accept edge as edge 1, so it must equal WAIT+1.
  task automatic do_req(input logic [31:0] addr, input logic we, input logic [2:0] mode,
                        input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                        input int hold, input string nm);
    exp_t e;
    int   n;
    sb_q.push_back(exp_t'{rdata: erd, err: eerr});
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_addr_i   = addr;
    req_we_i     = we;
    req_mode_i   = mode;
    req_wdata_i  = wdata;
    resp_ready_i = (hold == 0);
    n = 0;
    while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s accept: req_ready=%b required 1", nm, req_ready_o);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_wdata_i = 32'h0BAD_0BAD;
    n = 1;
    while (!resp_valid_o && n < 50) begin @(posedge clk); #1; n++; end
    e = sb_q.pop_front();
    checks++;
    if (n !== WAIT + 1) begin
      failures++;
      $display("FAIL %s latency: got %0d edges required %0d", nm, n, WAIT + 1);
    end
    checks++;
    if (resp_rdata_o !== e.rdata) begin
      failures++;
      $display("FAIL %s rdata: got %h required %h", nm, resp_rdata_o, e.rdata);
    end
    checks++;
    if (resp_err_o !== e.err) begin
      failures++;
      $display("FAIL %s err: got %b required %b", nm, resp_err_o, e.err);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid_o !== 1'b1 || resp_rdata_o !== e.rdata || resp_err_o !== e.err ||
          req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                 nm, i, resp_valid_o, resp_rdata_o, resp_err_o, req_ready_o, e.rdata, e.err);
      end
    end
    if (hold > 0) begin
      @(negedge clk);
      resp_ready_i = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid_o !== 1'b0 || resp_rdata_o !== 32'd0 || resp_err_o !== 1'b0 ||
        req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s complete: valid=%b rdata=%h err=%b ready=%b required 0 0 0 1",
               nm, resp_valid_o, resp_rdata_o, resp_err_o, req_ready_o);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; req_valid_i = 1'b1; req_addr_i = '0; req_we_i = 1'b0;
    req_mode_i = 3'b010; req_wdata_i = '0; resp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'd0 ||
        resp_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: ready=%b valid=%b rdata=%h err=%b required 0 0 0 0",
               req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: ready=%b required 1", req_ready_o);
    end
  endtask

  task automatic test_word;
    do_req(32'h10, 1'b1, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 0, "sw_10");
    do_req(32'h10, 1'b0, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 0, "lw_10");
  endtask

  task automatic test_subword;
    do_req(32'h13, 1'b0, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0, 0, "lb_13");
    do_req(32'h13, 1'b0, 3'b100, 32'h0, 32'h000000DE, 1'b0, 0, "lbu_13");
    do_req(32'h12, 1'b0, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0, 0, "lh_12");
    do_req(32'h10, 1'b0, 3'b101, 32'h0, 32'h0000BEEF, 1'b0, 0, "lhu_10");
    do_req(32'h11, 1'b0, 3'b000, 32'h0, 32'hFFFFFFBE, 1'b0, 0, "lb_11");
    do_req(32'h10, 1'b0, 3'b001, 32'h0, 32'hFFFFBEEF, 1'b0, 0, "lh_10");
  endtask

  task automatic test_store_merge;
    do_req(32'h11, 1'b1, 3'b000, 32'hFFFFFF55, 32'h0, 1'b0, 0, "sb_11");
    do_req(32'h10, 1'b0, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0, 0, "lw_after_sb");
    do_req(32'h12, 1'b1, 3'b001, 32'h1234A5A5, 32'h0, 1'b0, 0, "sh_12");
    do_req(32'h10, 1'b0, 3'b010, 32'h0, 32'hA5A555EF, 1'b0, 0, "lw_after_sh");
  endtask

  task automatic test_errors;
    do_req(32'h12,   1'b0, 3'b010, 32'h0,       32'h0, 1'b1, 0, "lw_misaligned");
    do_req(32'h11,   1'b0, 3'b101, 32'h0,       32'h0, 1'b1, 0, "lhu_misaligned");
    do_req(32'h0,    1'b1, 3'b010, 32'h11112222, 32'h0, 1'b0, 0, "sw_0");
    do_req(32'h1000, 1'b1, 3'b010, 32'h99999999, 32'h0, 1'b1, 0, "sw_oor");
    do_req(32'h1000, 1'b0, 3'b010, 32'h0,       32'h0, 1'b1, 0, "lw_oor");
    do_req(32'h0,    1'b0, 3'b010, 32'h0, 32'h11112222, 1'b0, 0, "lw_0_unchanged");
    do_req(32'h10,   1'b1, 3'b100, 32'h77777777, 32'h0, 1'b1, 0, "store_mode100");
    do_req(32'h10,   1'b0, 3'b011, 32'h0,       32'h0, 1'b1, 0, "load_mode011");
    do_req(32'h10,   1'b0, 3'b110, 32'h0,       32'h0, 1'b1, 0, "load_mode110");
    do_req(32'h10,   1'b0, 3'b010, 32'h0, 32'hA5A555EF, 1'b0, 0, "lw_10_unchanged");
  endtask

  task automatic test_backpressure;
    do_req(32'h10, 1'b0, 3'b010, 32'h0, 32'hA5A555EF, 1'b0, 5, "bp_lw");
    do_req(32'h14, 1'b1, 3'b010, 32'h5A5A5A5A, 32'h0, 1'b0, 3, "bp_sw");
    do_req(32'h14, 1'b0, 3'b010, 32'h0, 32'h5A5A5A5A, 1'b0, 0, "lw_after_bp_sw");
  endtask

  task automatic test_back_to_back;
    logic [31:0] model [4];
    for (int i = 0; i < 4; i++) begin
      model[i] = $urandom;
      do_req(32'h40 + 32'(4 * i), 1'b1, 3'b010, model[i], 32'h0, 1'b0, 0, "b2b_sw");
    end
    for (int i = 0; i < 4; i++)
      do_req(32'h40 + 32'(4 * i), 1'b0, 3'b010, 32'h0, model[i], 1'b0, 0, "b2b_lw");
  endtask

  task automatic test_reset_mid;
    do_req(32'h20, 1'b1, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0, 0, "sw_20_init");
    for (int k = 0; k < 2; k++) begin
      // k=0: reset in the first wait cycle; k=1: reset on the commit edge
      @(negedge clk);
      req_valid_i = 1'b1; req_addr_i = 32'h20; req_we_i = 1'b1;
      req_mode_i = 3'b010; req_wdata_i = 32'h00001234;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      @(negedge clk);
      if (k == 1) @(negedge clk);
      rst_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      checks++;
      if (req_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL rst_mid%0d ready: got %b required 1", k, req_ready_o);
      end
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        checks++;
        if (resp_valid_o !== 1'b0) begin
          failures++;
          $display("FAIL rst_mid%0d no_resp: valid=%b required 0", k, resp_valid_o);
        end
      end
      do_req(32'h20, 1'b0, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0, 0, "lw_20_after_rst");
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_store_merge();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
